// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS ID-stage hazard/stall controller.
// Stall lengths are the number of bubble cycles each unresolvable hazard needs.
package hazard_pkg;

  localparam int REG_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam int LOAD_USE_STALL    = 1;
  localparam int BR_ALU_STALL      = 1;
  localparam int BR_LOAD_EX_STALL  = 2;
  localparam int BR_LOAD_MEM_STALL = 1;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the ID-stage pipeline and the hazard controller.
// The pipeline is the master (supplies hazard inputs), the controller is the slave.
interface hazard_stall_ctrl_if #(
  parameter int REG_W  = hazard_pkg::REG_W,
  parameter int PERF_W = 32
);
  logic [REG_W-1:0]  IDRegisterRs;
  logic [REG_W-1:0]  IDRegisterRt;
  logic              IDUsesRt;
  logic              IDBranch;
  logic              IDJump;
  logic              BranchTaken;
  logic              EXMemRead;
  logic              EXRegWrite;
  logic [REG_W-1:0]  EX_WriteReg;
  logic              MEMMemRead;
  logic [REG_W-1:0]  MEM_WriteReg;
  logic              PCWrite;
  logic              IFIDWrite;
  logic              IDEXFlush;
  logic              IFIDFlush;
  logic              Stalling;
  logic [PERF_W-1:0] StallCycles;
  logic [PERF_W-1:0] FlushCount;

  modport master (
    output IDRegisterRs, IDRegisterRt, IDUsesRt, IDBranch, IDJump, BranchTaken,
           EXMemRead, EXRegWrite, EX_WriteReg, MEMMemRead, MEM_WriteReg,
    input  PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Stalling, StallCycles, FlushCount
  );

  modport slave (
    input  IDRegisterRs, IDRegisterRt, IDUsesRt, IDBranch, IDJump, BranchTaken,
           EXMemRead, EXRegWrite, EX_WriteReg, MEMMemRead, MEM_WriteReg,
    output PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, Stalling, StallCycles, FlushCount
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational stall-length classifier: returns how many bubble cycles the
// instruction in ID needs (0 = none). First matching rule wins.
module hazard_detect #(
  parameter int REG_W = 5,
  parameter int CNT_W = 2
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_write_reg,
  output logic [CNT_W-1:0] n
);
  import hazard_pkg::*;

  logic ex_match;
  logic mem_match;

  // $0 is hardwired zero, so a write to it never produces a dependency
  assign ex_match  = (ex_write_reg != '0) &&
                     ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
  assign mem_match = (mem_write_reg != '0) &&
                     ((mem_write_reg == id_rs) || (id_uses_rt && (mem_write_reg == id_rt)));

  always_comb begin
    n = '0;
    if (id_branch && ex_mem_read && ex_match)
      n = CNT_W'(BR_LOAD_EX_STALL);
    else if (id_branch && ex_reg_write && ex_match)
      n = CNT_W'(BR_ALU_STALL);
    else if (id_branch && mem_mem_read && mem_match)
      n = CNT_W'(BR_LOAD_MEM_STALL);
    else if (!id_branch && ex_mem_read && ex_match)
      n = CNT_W'(LOAD_USE_STALL);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall/bubble/flush controller with a registered multi-cycle stall FSM.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | evaluate hazards each cycle; single-cycle stalls stay here
// STALL | hold PC and IF/ID, bubble ID/EX until cnt reaches 1
module hazard_stall_ctrl #(
  parameter int REG_W  = hazard_pkg::REG_W,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_ctrl_if.slave bus
);
  import hazard_pkg::*;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] n;
  logic             pc_write, ifid_write, idex_flush, ifid_flush, stalling;

  hazard_detect #(.REG_W(REG_W), .CNT_W(CNT_W)) u_detect (
    .id_rs         (bus.IDRegisterRs),
    .id_rt         (bus.IDRegisterRt),
    .id_uses_rt    (bus.IDUsesRt),
    .id_branch     (bus.IDBranch),
    .ex_mem_read   (bus.EXMemRead),
    .ex_reg_write  (bus.EXRegWrite),
    .ex_write_reg  (bus.EX_WriteReg),
    .mem_mem_read  (bus.MEMMemRead),
    .mem_write_reg (bus.MEM_WriteReg),
    .n             (n)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    idex_flush = 1'b0;
    ifid_flush = 1'b0;
    stalling   = 1'b0;
    if (reset) begin
      idex_flush = 1'b1;
      ifid_flush = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (n != '0) begin
            // stall wins: a taken branch is not acted on while entering a stall
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (n > CNT_W'(1)) begin
              state_next = STALL;
              cnt_next   = n - CNT_W'(1);
            end
          end else begin
            ifid_flush = (bus.IDBranch && bus.BranchTaken) || bus.IDJump;
          end
        end
        STALL: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          stalling   = 1'b1;
          if (cnt <= CNT_W'(1)) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign bus.PCWrite   = pc_write;
  assign bus.IFIDWrite = ifid_write;
  assign bus.IDEXFlush = idex_flush;
  assign bus.IFIDFlush = ifid_flush;
  assign bus.Stalling  = stalling;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles, flush_count;

  // saturating counters; ifid_flush is forced high in reset but the async clear dominates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + PERF_W'(1);
      if (ifid_flush && (flush_count != '1))
        flush_count <= flush_count + PERF_W'(1);
    end
  end

  assign bus.StallCycles = stall_cycles;
  assign bus.FlushCount  = flush_count;
`else
  assign bus.StallCycles = '0;
  assign bus.FlushCount  = '0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. It sits beside the ID stage and decides stall, bubble and flush.
- Covers hazards that EX-stage forwarding cannot resolve: load-use, and branch operands needed early in ID.
- Drives PC, IF/ID and ID/EX write/flush controls.
- Holds multi-cycle stalls with a registered FSM and down-counter, so each stall runs its exact length without re-detection.

Parameters:
REG_W, 5, register specifier width
CNT_W, 2, stall down-counter width (max stall 3)
PERF_W, 32, performance counter width (optional feature only)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
IDRegisterRs  input  REG_W  rs of instruction in ID
IDRegisterRt  input  REG_W  rt of instruction in ID
IDUsesRt  input  1  ID instruction reads rt as a source (R-type, beq/bne, sw)
IDBranch  input  1  beq/bne in ID (compared in ID)
IDJump  input  1  j/jal in ID
BranchTaken  input  1  ID comparator result, valid when IDBranch=1
EXMemRead  input  1  load in EX
EXRegWrite  input  1  EX instruction writes a register
EX_WriteReg  input  REG_W  EX destination register
MEMMemRead  input  1  load in MEM
MEM_WriteReg  input  REG_W  MEM destination register
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/ID register write enable
IDEXFlush  output  1  zero ID/EX control fields (insert bubble)
IFIDFlush  output  1  squash instruction in IF/ID
Stalling  output  1  FSM in STALL state (debug/visibility)
StallCycles  output  PERF_W  total stall cycles (optional feature)
FlushCount  output  PERF_W  total IF/ID flushes (optional feature)

Behaviour:
- Register match: a source matches destination D when D != 0 and (D == IDRegisterRs or (IDUsesRt and D == IDRegisterRt)).
- Hazard length N, computed in IDLE only. Take the first rule that applies:
  - IDBranch, EXMemRead, EX match -> N=2
  - IDBranch, EXRegWrite, not EXMemRead, EX match -> N=1
  - IDBranch, MEMMemRead, MEM match -> N=1
  - not IDBranch, EXMemRead, EX match -> N=1
  - otherwise -> N=0
- FSM states: IDLE, STALL. Register cnt is CNT_W wide.
- IDLE with N>0:
  - Same cycle (Mealy): PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0.
  - If N=1, stay in IDLE (single-cycle stall).
  - If N>=2, load cnt=N-1 and go to STALL.
- STALL:
  - Outputs PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0, Stalling=1.
  - Hazard inputs and BranchTaken are ignored.
  - cnt decrements each cycle; the cycle with cnt==1 returns to IDLE with cnt=0.
- IDLE with N=0:
  - PCWrite=1, IFIDWrite=1, IDEXFlush=0.
  - IFIDFlush=1 iff (IDBranch and BranchTaken) or IDJump.
- Priority: stall beats flush. BranchTaken is never acted on while a stall is in force or being entered.
- Back-to-back stalls: the cycle after STALL exits is evaluated normally in IDLE. A fresh hazard at that point is legal and starts a new stall.
- Reset value of all outputs:
  - Async reset sets state=IDLE, cnt=0.
  - While reset is held: PCWrite=1, IFIDWrite=1, IDEXFlush=1, IFIDFlush=1, Stalling=0, counters=0.
- Reset mid-stall aborts the stall immediately.
- Register $0 never creates a hazard.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: StallCycles increments on every cycle with PCWrite=0. FlushCount increments on every cycle with IFIDFlush=1 outside reset. Both saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_W
  - the state encoding (IDLE=1'b0, STALL=1'b1)
  - the stall-length constants (LOAD_USE_STALL=1, BR_ALU_STALL=1, BR_LOAD_EX_STALL=2, BR_LOAD_MEM_STALL=1)
- One natural sub-module, hazard_detect: combinational N classifier. The FSM, counter and perf counters stay in the top.

Test Plan:
- Load-use: EXMemRead=1, EX_WriteReg=8, IDRegisterRs=8, IDBranch=0 -> exactly 1 cycle with PCWrite=0, IDEXFlush=1; next cycle (EXMemRead=0) PCWrite=1.
- Branch after load: IDBranch=1, EXMemRead=1, EX_WriteReg=9, IDRegisterRt=9, IDUsesRt=1, BranchTaken=1 -> 2 stall cycles (Stalling=1 in the second), IFIDFlush=0 during both; after the hazard clears with BranchTaken=1 -> IFIDFlush=1 for 1 cycle.
- Branch after ALU op: IDBranch=1, EXRegWrite=1, EX_WriteReg=10, IDRegisterRs=10 -> 1 stall cycle. Same stimulus with EX_WriteReg=0 -> no stall.
- rt ignored: IDUsesRt=0, EXMemRead=1, EX_WriteReg=5, IDRegisterRt=5 -> no stall.
- Reset mid-stall: assert reset during the second cycle of a 2-cycle stall -> state IDLE immediately, Stalling=0 asynchronously, PCWrite=1 on release.
- HAZARD_PERF_CNT_EN: one 2-cycle stall, one 1-cycle stall, one jump -> StallCycles=3, FlushCount=1. Without the macro both read 0.
